vx_cache_rsp_sched: RTL and testbench
=====================================

VX_CACHE_RSP_SCHED -- requirements
Module: VX_cache_rsp_sched

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4: number of core response lanes.
REQ-002 SHALL have parameter NUM_BANKS, default 2: number of cache banks, a power of two, at least 2 and at most NUM_REQS.
REQ-003 SHALL have parameter WORD_SIZE, default 4: word size in bytes; WORD_WIDTH = WORD_SIZE*8.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: core request tag width.
REQ-005 SHALL derive REQ_SEL_BITS = LOG2UP(NUM_REQS) and BANK_SEL_BITS = LOG2UP(NUM_BANKS).
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port per_bank_core_rsp_valid, input, NUM_BANKS bits: bank response valid.
REQ-009 SHALL have port per_bank_core_rsp_data, input, NUM_BANKS x WORD_WIDTH bits: bank response word.
REQ-010 SHALL have port per_bank_core_rsp_idx, input, NUM_BANKS x REQ_SEL_BITS bits: destination lane of the bank response.
REQ-011 SHALL have port per_bank_core_rsp_tag, input, NUM_BANKS x TAG_WIDTH bits: bank response tag.
REQ-012 SHALL have port per_bank_core_rsp_ready, output, NUM_BANKS bits: bank response accepted.
REQ-013 SHALL have port core_rsp_valid, output, NUM_REQS bits: lane response valid.
REQ-014 SHALL have port core_rsp_data, output, NUM_REQS x WORD_WIDTH bits: lane response word.
REQ-015 SHALL have port core_rsp_tag, output, NUM_REQS x TAG_WIDTH bits: lane response tag.
REQ-016 SHALL have port core_rsp_ready, input, NUM_REQS bits: core accepts the lane response.
REQ-017 SHALL have port perf_stalls, output, 32 bits: saturating count of bank stall cycles.

Function
REQ-018 SHALL consider bank b a requester of lane r iff per_bank_core_rsp_valid[b] is 1 and per_bank_core_rsp_idx[b] equals r.
REQ-019 SHALL keep one round-robin pointer per lane, ptr[r], BANK_SEL_BITS wide.
REQ-020 SHALL grant lane r to the first requesting bank found scanning ptr[r], ptr[r]+1, ... modulo NUM_BANKS.
REQ-021 SHALL hold one output register stage per lane, consisting of valid, data and tag.
REQ-022 SHALL define lane r as able to accept (lane_acc[r]) iff its register is empty or core_rsp_ready[r] is 1 in the same cycle.
REQ-023 SHALL assert per_bank_core_rsp_ready[b] combinationally iff bank b holds the grant of its target lane and that lane's lane_acc is 1.
REQ-024 SHALL, on bank b's handshake into lane r, load the register of lane r with bank b's data and tag, set its valid, and set ptr[r] to (b+1) mod NUM_BANKS.
REQ-025 SHALL clear the valid of lane r when core_rsp_ready[r] is 1 and no new load occurs into lane r.
REQ-026 SHALL allow simultaneous drain and load on a lane, sustaining 1 response per lane per cycle.
REQ-027 SHALL give a latency of exactly 1 cycle from a bank handshake to core_rsp_valid, with no combinational path from per_bank_* to core_rsp_*.
REQ-028 SHALL hold data and tag stable while core_rsp_valid is 1 and core_rsp_ready is 0.
REQ-029 SHALL leave ptr[r] unchanged when lane r has no handshake, including when a grant is blocked by lane_acc = 0.
REQ-030 SHALL serve banks targeting distinct lanes in the same cycle in parallel, without interaction between lanes.
REQ-031 SHALL increment perf_stalls by the number of banks with valid 1 and ready 0 in each cycle, saturating at 0xFFFFFFFF.
REQ-032 SHALL not depend on per_bank_core_rsp_ready when deciding per_bank_core_rsp_valid; the valid/ready handshake is standard and requires no ordering.

Reset
REQ-033 SHALL, during reset, clear all core_rsp_valid bits, set all ptr[r] to 0, and set perf_stalls to 0.
REQ-034 SHALL, during reset, drive per_bank_core_rsp_ready to 0 and discard responses held in lane registers.
REQ-035 SHALL leave core_rsp_data and core_rsp_tag unspecified while core_rsp_valid is 0.

Verification (NUM_REQS=4, NUM_BANKS=2)
REQ-036 SHALL pass this scenario: bank0 sends idx=2, tag=0x11, data=0xA; core_rsp_ready=1111 -> bank0 ready that cycle; the next cycle core_rsp_valid=0100 and tag[2]=0x11.
REQ-037 SHALL pass this scenario: both banks send idx=1 for 4 cycles; core_rsp_ready=1111 -> grants go bank0, bank1, bank0, bank1 and perf_stalls=4.
REQ-038 SHALL pass this scenario: bank0 sends idx=0 and bank1 sends idx=3 in the same cycle -> both are ready and the next cycle core_rsp_valid=1001.
REQ-039 SHALL pass this scenario: lane 2 is full and core_rsp_ready[2]=0 for 3 cycles while bank1 sends idx=2 -> bank1 ready=0, lane 2 data is stable, ptr[2] is unchanged, and bank1 is accepted in the cycle core_rsp_ready[2]=1.
REQ-040 SHALL pass this scenario: reset is asserted for 1 cycle while lanes 0 and 3 hold valid data -> the next cycle core_rsp_valid=0000 and perf_stalls=0, and the first contended grant afterwards goes to bank0.

Source files
------------

// File: rtl/vx_cache_rsp_sched.sv
// -----------------------------------------------------------------------------
// vx_cache_rsp_sched
// Routes cache bank responses to core response lanes. Each lane arbitrates
// round-robin among the banks that target it. Each lane has one output
// register stage, so a lane can drain and load in the same cycle.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   per_bank_core_rsp_valid    per-bank response valid
//   per_bank_core_rsp_data     per-bank response word
//   per_bank_core_rsp_idx      per-bank destination lane
//   per_bank_core_rsp_tag      per-bank response tag
//   per_bank_core_rsp_ready    per-bank accept (combinational from grant + lane state)
//   core_rsp_valid/data/tag    registered per-lane response
//   core_rsp_ready             per-lane core accept
//   perf_stalls                saturating count of bank valid-without-ready cycles
//
// NUM_BANKS must be a power of two, so pointer arithmetic wraps naturally.
// -----------------------------------------------------------------------------
module vx_cache_rsp_sched #(
  parameter int unsigned NUM_REQS  = 4,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned TAG_WIDTH = 8,
  localparam int unsigned WORD_WIDTH    = WORD_SIZE * 8,
  localparam int unsigned REQ_SEL_BITS  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int unsigned BANK_SEL_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_BANKS-1:0]                     per_bank_core_rsp_valid,
  input  logic [NUM_BANKS-1:0][WORD_WIDTH-1:0]     per_bank_core_rsp_data,
  input  logic [NUM_BANKS-1:0][REQ_SEL_BITS-1:0]   per_bank_core_rsp_idx,
  input  logic [NUM_BANKS-1:0][TAG_WIDTH-1:0]      per_bank_core_rsp_tag,
  output logic [NUM_BANKS-1:0]                     per_bank_core_rsp_ready,
  output logic [NUM_REQS-1:0]                      core_rsp_valid,
  output logic [NUM_REQS-1:0][WORD_WIDTH-1:0]      core_rsp_data,
  output logic [NUM_REQS-1:0][TAG_WIDTH-1:0]       core_rsp_tag,
  input  logic [NUM_REQS-1:0]                      core_rsp_ready,
  output logic [31:0]                              perf_stalls
);

  localparam int unsigned CNT_W = $clog2(NUM_BANKS + 1);

  logic [NUM_REQS-1:0][BANK_SEL_BITS-1:0] ptr_q;
  logic [NUM_REQS-1:0]                    valid_q;
  logic [NUM_REQS-1:0][WORD_WIDTH-1:0]    data_q;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0]     tag_q;
  logic [31:0]                            stalls_q;
  logic [31:0]                            stalls_d;

  logic [NUM_REQS-1:0][NUM_BANKS-1:0]     req_c;
  logic [NUM_REQS-1:0]                    gnt_any_c;
  logic [NUM_REQS-1:0][BANK_SEL_BITS-1:0] gnt_bank_c;
  logic [NUM_REQS-1:0]                    lane_acc_c;
  logic [NUM_REQS-1:0]                    load_c;
  logic [NUM_BANKS-1:0]                   bank_rdy_c;
  logic [CNT_W-1:0]                       stall_cnt_c;
  logic [32:0]                            stall_sum_c;

  // Request matrix: bank b requests lane r when valid and targeting r.
  always_comb begin
    req_c = '0;
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (per_bank_core_rsp_valid[b] &&
            (per_bank_core_rsp_idx[b] == REQ_SEL_BITS'(r))) begin
          req_c[r][b] = 1'b1;
        end
      end
    end
  end

  // Per-lane round-robin: first requester scanning upward from ptr_q[r].
  always_comb begin
    logic [BANK_SEL_BITS-1:0] sel;
    gnt_any_c  = '0;
    gnt_bank_c = '0;
    sel        = '0;
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
        sel = ptr_q[r] + BANK_SEL_BITS'(k);
        if (!gnt_any_c[r] && req_c[r][sel]) begin
          gnt_any_c[r]  = 1'b1;
          gnt_bank_c[r] = sel;
        end
      end
    end
  end

  // A lane accepts when empty or draining this cycle; reset blocks all loads.
  always_comb begin
    lane_acc_c = ~valid_q | core_rsp_ready;
    load_c     = gnt_any_c & lane_acc_c & {NUM_REQS{~reset}};
  end

  // Bank ready: this bank owns the grant of its target lane and that lane loads.
  always_comb begin
    bank_rdy_c = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned r = 0; r < NUM_REQS; r++) begin
        if (per_bank_core_rsp_valid[b] &&
            (per_bank_core_rsp_idx[b] == REQ_SEL_BITS'(r)) &&
            load_c[r] && (gnt_bank_c[r] == BANK_SEL_BITS'(b))) begin
          bank_rdy_c[b] = 1'b1;
        end
      end
    end
  end

  // Stall accounting with saturation at all-ones.
  always_comb begin
    stall_cnt_c = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      stall_cnt_c = stall_cnt_c +
                    CNT_W'(per_bank_core_rsp_valid[b] & ~bank_rdy_c[b]);
    end
    stall_sum_c = {1'b0, stalls_q} + 33'(stall_cnt_c);
    stalls_d    = stall_sum_c[32] ? 32'hFFFF_FFFF : stall_sum_c[31:0];
  end

  // Lane valid and arbitration pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      ptr_q    <= '0;
      stalls_q <= '0;
    end else begin
      stalls_q <= stalls_d;
      for (int unsigned r = 0; r < NUM_REQS; r++) begin
        if (load_c[r]) begin
          valid_q[r] <= 1'b1;
          ptr_q[r]   <= gnt_bank_c[r] + BANK_SEL_BITS'(1);
        end else if (core_rsp_ready[r]) begin
          valid_q[r] <= 1'b0;
        end
      end
    end
  end

  // Payload registers; contents are don't-care while the lane is invalid.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_REQS; r++) begin
      if (load_c[r]) begin
        data_q[r] <= per_bank_core_rsp_data[gnt_bank_c[r]];
        tag_q[r]  <= per_bank_core_rsp_tag[gnt_bank_c[r]];
      end
    end
  end

  assign per_bank_core_rsp_ready = bank_rdy_c;
  assign core_rsp_valid          = valid_q;
  assign core_rsp_data           = data_q;
  assign core_rsp_tag            = tag_q;
  assign perf_stalls             = stalls_q;

endmodule

// File: tb/tb_vx_cache_rsp_sched.sv
// -----------------------------------------------------------------------------
// tb_vx_cache_rsp_sched
// Directed scenarios followed by randomized traffic. A reference model turns
// accepted bank responses into per-lane expected queues; a monitor pops and
// compares whenever a lane handshake is presented.
// -----------------------------------------------------------------------------
module tb_vx_cache_rsp_sched;

  localparam int NR = 4;
  localparam int NB = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
  } rsp_t;

  logic                 clk;
  logic                 reset;
  logic [NB-1:0]        bv;
  logic [NB-1:0][31:0]  bdata;
  logic [NB-1:0][1:0]   bidx;
  logic [NB-1:0][7:0]   btag;
  logic [NB-1:0]        brdy;
  logic [NR-1:0]        cvalid;
  logic [NR-1:0][31:0]  cdata;
  logic [NR-1:0][7:0]   ctag;
  logic [NR-1:0]        cready;
  logic [31:0]          stalls;

  int                   n_checks = 0;
  int                   n_fail   = 0;
  bit                   mon_en   = 0;

  rsp_t                 q_m [NR][$];
  int                   ptr_m [NR];
  longint unsigned      exp_stalls;

  vx_cache_rsp_sched #(
    .NUM_REQS (NR),
    .NUM_BANKS(NB),
    .WORD_SIZE(4),
    .TAG_WIDTH(8)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .per_bank_core_rsp_valid(bv),
    .per_bank_core_rsp_data (bdata),
    .per_bank_core_rsp_idx  (bidx),
    .per_bank_core_rsp_tag  (btag),
    .per_bank_core_rsp_ready(brdy),
    .core_rsp_valid         (cvalid),
    .core_rsp_data          (cdata),
    .core_rsp_tag           (ctag),
    .core_rsp_ready         (cready),
    .perf_stalls            (stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle once inputs are stable and after the
  // monitor has retired this cycle's drains.
  logic [NB-1:0] exp_rdy;
  rsp_t          ent_m;
  bit            acc_m;
  bit            found_m;
  int            bsel_m;
  always @(negedge clk) begin
    #1;
    exp_rdy = '0;
    if (reset) begin
      chk("bank_rdy_in_reset", 64'(brdy), 64'(0));
      for (int r = 0; r < NR; r++) begin
        q_m[r].delete();
        ptr_m[r] = 0;
      end
      exp_stalls = 0;
    end else begin
      for (int r = 0; r < NR; r++) begin
        acc_m   = (q_m[r].size() == 0) || cready[r];
        found_m = 0;
        for (int k = 0; k < NB; k++) begin
          bsel_m = (ptr_m[r] + k) % NB;
          if (!found_m && bv[bsel_m] && (bidx[bsel_m] == 2'(r))) begin
            found_m = 1;
            if (acc_m) begin
              exp_rdy[bsel_m] = 1'b1;
              ent_m.data = bdata[bsel_m];
              ent_m.tag  = btag[bsel_m];
              q_m[r].push_back(ent_m);
              ptr_m[r] = (bsel_m + 1) % NB;
            end
          end
        end
      end
      chk("bank_rdy", 64'(brdy), 64'(exp_rdy));
      for (int b = 0; b < NB; b++) begin
        if (bv[b] && !exp_rdy[b] && exp_stalls < 64'hFFFF_FFFF) exp_stalls++;
      end
    end
  end

  // Monitor: lane occupancy, payload on each handshake, stall counter.
  rsp_t ent_mon;
  always @(negedge clk) begin
    if (mon_en) begin
      for (int r = 0; r < NR; r++) begin
        chk("lane_valid", 64'(cvalid[r]), 64'(q_m[r].size() != 0));
        if (cvalid[r] && cready[r] && q_m[r].size() != 0) begin
          ent_mon = q_m[r].pop_front();
          chk("lane_data", 64'(cdata[r]), 64'(ent_mon.data));
          chk("lane_tag", 64'(ctag[r]), 64'(ent_mon.tag));
        end
      end
      chk("perf_stalls", 64'(stalls), exp_stalls);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] s0;
  logic [31:0] d_hold;
  logic [31:0] d_new;

  initial begin
    reset  = 1'b1;
    bv     = '0;
    bdata  = '0;
    bidx   = '0;
    btag   = '0;
    cready = '0;
    exp_stalls = 0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("reset_valid", 64'(cvalid), 64'(0));
    chk("reset_stalls", 64'(stalls), 64'(0));
    mon_en = 1;

    // Single response into lane 2.
    cready   = 4'hF;
    bv       = 2'b01;
    bidx[0]  = 2'd2;
    btag[0]  = 8'h11;
    bdata[0] = 32'hA;
    #1 chk("r036_rdy", 64'(brdy), 64'(2'b01));
    cyc();
    chk("r036_valid", 64'(cvalid), 64'(4'b0100));
    chk("r036_tag", 64'(ctag[2]), 64'(8'h11));
    bv = '0;
    cyc();

    // Contention on lane 1 alternates banks.
    s0      = stalls;
    bv      = 2'b11;
    bidx[0] = 2'd1;
    bidx[1] = 2'd1;
    for (int i = 0; i < 4; i++) begin
      bdata[0] = $urandom;
      bdata[1] = $urandom;
      btag[0]  = 8'(i);
      btag[1]  = 8'(i + 8'h80);
      #1 chk("r037_grant", 64'(brdy), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      cyc();
    end
    bv = '0;
    chk("r037_stalls", 64'(stalls - s0), 64'(4));
    cyc();

    // Distinct lanes served in parallel.
    bv      = 2'b11;
    bidx[0] = 2'd0;
    bidx[1] = 2'd3;
    #1 chk("r038_rdy", 64'(brdy), 64'(2'b11));
    cyc();
    chk("r038_valid", 64'(cvalid), 64'(4'b1001));

    // Reset while lanes 0 and 3 hold data.
    bv     = '0;
    cready = '0;
    cyc();
    chk("r040_held", 64'(cvalid), 64'(4'b1001));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("r040_valid", 64'(cvalid), 64'(0));
    chk("r040_stalls", 64'(stalls), 64'(0));
    cready  = 4'hF;
    bv      = 2'b11;
    bidx[0] = 2'd2;
    bidx[1] = 2'd2;
    #1 chk("r040_first_grant", 64'(brdy), 64'(2'b01));
    cyc();

    // Lane 2 blocked: both banks wait, pointer must still favour bank1 on release.
    cready   = 4'b1011;
    d_hold   = cdata[2];
    d_new    = 32'hDEAD_0001;
    bdata[1] = d_new;
    btag[1]  = 8'h39;
    for (int i = 0; i < 3; i++) begin
      #1 chk("r039_blocked_rdy", 64'(brdy), 64'(2'b00));
      chk("r039_stable", 64'(cdata[2]), 64'(d_hold));
      cyc();
    end
    cready = 4'hF;
    #1 chk("r039_release_rdy", 64'(brdy), 64'(2'b10));
    cyc();
    chk("r039_new_data", 64'(cdata[2]), 64'(d_new));
    bv = '0;
    cyc();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      bv     = 2'($urandom);
      cready = 4'($urandom);
      for (int b = 0; b < NB; b++) begin
        bidx[b]  = 2'($urandom_range(0, 3));
        bdata[b] = $urandom;
        btag[b]  = 8'($urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset  = 1'b0;
    bv     = '0;
    cready = 4'hF;
    cyc();
    cyc();
    cyc();
    for (int r = 0; r < NR; r++) begin
      chk("drain_empty", 64'(q_m[r].size()), 64'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
